// File: rtl/lane_serializer_if.sv
// Handshake bundle for lane_serializer: a packed input word in, a lane stream out.
// The serializer takes the slave modport; the producer/consumer side takes master.
interface lane_serializer_if #(
  parameter int WIDTH = 2,
  parameter int LANES = 4
);
  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;

  logic                        in_valid;
  logic                        in_ready;
  logic [LANES-1:0][WIDTH-1:0] in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [WIDTH-1:0]            out_data;
  logic [IDXW-1:0]             out_index;
  logic                        out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/lane_serializer.sv
// Packed-word to lane-stream serializer, one lane per cycle, no bubble between words.
// Defining LANE_SERIALIZER_MSB_FIRST_EN emits lanes from LANES-1 down to 0.
module lane_serializer #(
  parameter int WIDTH = 2,
  parameter int LANES = 4,
  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input logic              clk,
  input logic              rst_n,
  lane_serializer_if.slave bus
);

`ifdef LANE_SERIALIZER_MSB_FIRST_EN
  localparam logic [IDXW-1:0] FIRST_IDX = IDXW'(LANES - 1);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(0);
`else
  localparam logic [IDXW-1:0] FIRST_IDX = IDXW'(0);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(LANES - 1);
`endif

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                      state_r;
  logic [LANES-1:0][WIDTH-1:0] hold_r;
  logic [WIDTH-1:0]            out_data_r;
  logic [IDXW-1:0]             index_r;
  logic                        out_valid_r;

  logic                        last_s;
  logic                        in_ready_s;
  logic                        accept_s;
  logic                        beat_s;
  logic [IDXW-1:0]             next_idx_s;
  logic [WIDTH-1:0]            next_lane_s;

  // last is gated by state so an idle index never looks like a final lane
  assign last_s     = (state_r == SHIFT) && (index_r == LAST_IDX);
  assign in_ready_s = (state_r == IDLE) || (last_s && bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign beat_s     = out_valid_r && bus.out_ready;

  // next lane index and its data from the holding register
  always_comb begin
`ifdef LANE_SERIALIZER_MSB_FIRST_EN
    next_idx_s = index_r - IDXW'(1);
`else
    next_idx_s = index_r + IDXW'(1);
`endif
    next_lane_s = {WIDTH{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      next_lane_s = (IDXW'(i) == next_idx_s) ? hold_r[i] : next_lane_s;
    end
  end

  // serializer FSM with registered data, index and valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      hold_r      <= '0;
      out_data_r  <= {WIDTH{1'b0}};
      index_r     <= {IDXW{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            hold_r      <= bus.in_data;
            out_data_r  <= bus.in_data[FIRST_IDX];
            index_r     <= FIRST_IDX;
            out_valid_r <= 1'b1;
            state_r     <= SHIFT;
          end else begin
            out_valid_r <= 1'b0;
          end
        end
        SHIFT: begin
          if (accept_s) begin
            // reload coincides with the last-lane beat, so no bubble
            hold_r      <= bus.in_data;
            out_data_r  <= bus.in_data[FIRST_IDX];
            index_r     <= FIRST_IDX;
            out_valid_r <= 1'b1;
          end else if (beat_s && last_s) begin
            index_r     <= {IDXW{1'b0}};
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else if (beat_s) begin
            index_r     <= next_idx_s;
            out_data_r  <= next_lane_s;
          end else begin
            index_r     <= index_r;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          index_r     <= {IDXW{1'b0}};
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_index = index_r;
  assign bus.out_last  = last_s;

endmodule

// File: tb/tb_lane_serializer.sv
// Self-checking bench for lane_serializer: 4x2-bit instance driven from a vector
// table with a beat scoreboard, plus a 1x8-bit instance checked by hand.
module tb_lane_serializer;

`ifdef LANE_SERIALIZER_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  typedef struct {
    logic [7:0] word;
    logic [1:0] lane [4];
  } vec_t;

  typedef struct {
    logic [1:0] data;
    logic [1:0] idx;
    logic       last;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    n_cmp = 0;
  int    n_err = 0;
  int    cur_sel = 0;
  vec_t  tbl [5];
  beat_t sb [$];

  always #5 clk = ~clk;

  lane_serializer_if #(.WIDTH(2), .LANES(4)) a_if ();
  lane_serializer_if #(.WIDTH(8), .LANES(1)) b_if ();

  lane_serializer #(.WIDTH(2), .LANES(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  lane_serializer #(.WIDTH(8), .LANES(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // emission order position k -> lane number
  function automatic int lane_at(input int k);
    return MSB ? (3 - k) : k;
  endfunction

  task automatic push_word(input int sel);
    beat_t e;
    for (int k = 0; k < 4; k++) begin
      e.data = tbl[sel].lane[lane_at(k)];
      e.idx  = 2'(lane_at(k));
      e.last = (k == 3);
      sb.push_back(e);
    end
  endtask

  // scoreboard monitor: push on accept, pop and compare on each output beat
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (a_if.out_valid && a_if.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("beat_data", 32'(a_if.out_data), 32'(e.data));
          chk("beat_index", 32'(a_if.out_index), 32'(e.idx));
          chk("beat_last", 32'(a_if.out_last), 32'(e.last));
        end
      end
      if (a_if.in_valid && a_if.in_ready) push_word(cur_sel);
    end
  end

  // present word sel and return just after the accepting edge
  task automatic wait_accept(input int sel);
    bit ok;
    ok = 1'b0;
    cur_sel = sel;
    a_if.in_data = tbl[sel].word;
    a_if.in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (a_if.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!a_if.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    chk("idle_in_ready", 32'(a_if.in_ready), 32'd1);
  endtask

  initial begin
    tbl[0].word = 8'hE4; tbl[0].lane = '{2'd0, 2'd1, 2'd2, 2'd3};
    tbl[1].word = 8'h1B; tbl[1].lane = '{2'd3, 2'd2, 2'd1, 2'd0};
    tbl[2].word = 8'h00; tbl[2].lane = '{2'd0, 2'd0, 2'd0, 2'd0};
    tbl[3].word = 8'h72; tbl[3].lane = '{2'd2, 2'd0, 2'd3, 2'd1};
    tbl[4].word = 8'hFF; tbl[4].lane = '{2'd3, 2'd3, 2'd3, 2'd3};

    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(a_if.out_valid), 32'd0);
    chk("rst_out_data", 32'(a_if.out_data), 32'd0);
    chk("rst_out_index", 32'(a_if.out_index), 32'd0);
    chk("rst_out_last", 32'(a_if.out_last), 32'd0);
    chk("rst_in_ready", 32'(a_if.in_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // single words from the table, one-cycle latency to first lane
    for (int s = 0; s < 5; s++) begin
      wait_accept(s);
      a_if.in_valid = 1'b0;
      a_if.in_data = 'x;
      @(negedge clk);
      chk("first_valid", 32'(a_if.out_valid), 32'd1);
      chk("first_index", 32'(a_if.out_index), 32'(lane_at(0)));
      wait_idle();
    end

    // back-to-back E4 then 1B with no gap
    wait_accept(0);
    cur_sel = 1;
    a_if.in_data = tbl[1].word;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("b2b_valid", 32'(a_if.out_valid), 32'd1);
      chk("b2b_in_ready", 32'(a_if.in_ready), (k == 3 || k == 7) ? 32'd1 : 32'd0);
      if (k == 3) begin
        @(posedge clk);
        #1 a_if.in_valid = 1'b0;
        a_if.in_data = 'x;
      end
    end
    wait_idle();

    // backpressure on the second lane for three cycles
    wait_accept(0);
    a_if.in_valid = 1'b0;
    @(posedge clk);
    #1 a_if.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", 32'(a_if.out_valid), 32'd1);
      chk("bp_data", 32'(a_if.out_data), 32'(tbl[0].lane[lane_at(1)]));
      chk("bp_index", 32'(a_if.out_index), 32'(lane_at(1)));
      chk("bp_last", 32'(a_if.out_last), 32'd0);
      chk("bp_in_ready", 32'(a_if.in_ready), 32'd0);
    end
    @(posedge clk);
    #1 a_if.out_ready = 1'b1;
    wait_idle();

    // reset on the third lane discards the rest of the word
    wait_accept(0);
    a_if.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("pre_rst_index", 32'(a_if.out_index), 32'(lane_at(2)));
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", 32'(a_if.out_valid), 32'd0);
    chk("mid_rst_index", 32'(a_if.out_index), 32'd0);
    chk("mid_rst_in_ready", 32'(a_if.in_ready), 32'd1);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    wait_accept(2);
    a_if.in_valid = 1'b0;
    wait_idle();

    // single-lane instance: A5 then 3C back-to-back
    b_if.in_data = 8'hA5;
    b_if.in_valid = 1'b1;
    @(negedge clk);
    chk("l1_idle_ready", 32'(b_if.in_ready), 32'd1);
    @(posedge clk);
    #1 b_if.in_data = 8'h3C;
    @(negedge clk);
    chk("l1_valid0", 32'(b_if.out_valid), 32'd1);
    chk("l1_data0", 32'(b_if.out_data), 32'hA5);
    chk("l1_index0", 32'(b_if.out_index), 32'd0);
    chk("l1_last0", 32'(b_if.out_last), 32'd1);
    chk("l1_ready0", 32'(b_if.in_ready), 32'd1);
    @(posedge clk);
    #1 b_if.in_valid = 1'b0;
    @(negedge clk);
    chk("l1_valid1", 32'(b_if.out_valid), 32'd1);
    chk("l1_data1", 32'(b_if.out_data), 32'h3C);
    chk("l1_index1", 32'(b_if.out_index), 32'd0);
    chk("l1_last1", 32'(b_if.out_last), 32'd1);
    @(negedge clk);
    chk("l1_done", 32'(b_if.out_valid), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lane_serializer.md
Name: lane_serializer

Overview:
Parametrised packed-array serializer, the next generation of our plain packed-port modules. It accepts one word of LANES lanes, each WIDTH bits (packed [LANES-1:0][WIDTH-1:0]), through a valid/ready handshake. It emits the lanes one per cycle on a WIDTH-bit output stream with its own valid/ready handshake, a lane index and a last flag. It sits between wide datapath stages and narrow downstream consumers.

Parameters:
WIDTH, 2, bits per lane; must be >= 1
LANES, 4, lanes per input word; must be >= 1
IDXW, max(1,$clog2(LANES)), derived localparam; width of out_index

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  input word valid
in_ready  output  1  serializer can accept a word
in_data  input  [LANES-1:0][WIDTH-1:0]  packed input word
out_valid  output  1  out_data holds a valid lane
out_ready  input  1  downstream accepts the lane
out_data  output  WIDTH  current lane
out_index  output  IDXW  lane number of out_data
out_last  output  1  high on the final lane of a word

Behaviour:
- One clock, one synchronous active-low reset. Interface ports are named clk and rst_n.
- Reset (rst_n=0 at posedge): state=IDLE, out_valid=0, out_data=0, out_index=0, out_last=0, holding register cleared. in_ready is combinational and reads 1 once the state is IDLE.
- States are IDLE and SHIFT.
- IDLE:
  - in_ready=1, out_valid=0.
  - An input accept (in_valid & in_ready) captures in_data into the holding register.
  - Next cycle: state=SHIFT, out_valid=1, out_index=0, out_data=lane 0.
  - Latency from accept to first lane valid is 1 cycle.
- SHIFT:
  - out_valid=1.
  - An output beat (out_valid & out_ready) with out_index<LANES-1 increments out_index and presents the next lane the following cycle.
  - out_last = (out_index==LANES-1), combinational from the index.
  - Beat on the last lane with no input accept in the same cycle: next state=IDLE, out_valid=0.
- Back-to-back:
  - in_ready = IDLE | (SHIFT & out_last & out_ready).
  - An input accept coinciding with the last-lane beat reloads the holding register and restarts at index 0 with no bubble.
  - Sustained throughput is 1 lane/cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_index and out_last stay stable. in_valid is ignored unless in_ready=1.
- out_data and out_index are registered, so there is no combinational path from in_data to out_data. out_last and in_ready are combinational from state, index and out_ready.
- LANES=1: every beat has out_last=1, out_index stays 0, and each word takes one beat.
- Reset during SHIFT discards remaining lanes. No partial output follows reset.
- Index arithmetic is IDXW bits. It never exceeds LANES-1 and wraps only by reload to 0.
- X on in_data while in_valid=0 must not propagate to out_data.

Optional Feature:
LANE_SERIALIZER_MSB_FIRST_EN
- Defined: lanes are emitted from LANES-1 down to 0.
  - out_index counts LANES-1 down to 0.
  - out_last = (out_index==0).
  - Handshake and timing are otherwise identical.
- Undefined (default): lane 0 first, index counts up as above.

Test Plan:
1. Reset, then single word (WIDTH=2, LANES=4): in_data=8'b11_10_01_00 accepted with out_ready=1 -> out_data 0,1,2,3 on 4 consecutive cycles, out_index 0..3, out_last only on index 3, then out_valid=0 and in_ready=1.
2. Back-to-back: words 8'hE4 and 8'h1B, in_valid held and out_ready=1 -> 8 consecutive beats 0,1,2,3,3,2,1,0 with no gap. in_ready pulses high on the last-lane cycle.
3. Backpressure: out_ready=0 for 3 cycles at index 1 of 8'hE4 -> out_data=1 and out_index=1 held stable. in_ready=0 throughout. Stream resumes with 2,3.
4. Reset mid-word: assert rst_n=0 at index 2 -> next cycle out_valid=0, out_index=0, in_ready=1. A new word 8'h00 then streams 0,0,0,0.
5. LANES=1, WIDTH=8: words 8'hA5 then 8'h3C -> beats A5 then 3C, each with out_last=1 and out_index=0.
6. With LANE_SERIALIZER_MSB_FIRST_EN defined: in_data=8'hE4 -> out_data 3,2,1,0, out_index 3,2,1,0, out_last on index 0.
